// File: rtl/i2c_temp_poller_if.sv
// -----------------------------------------------------------------------------
// wishbone_b3 : Wishbone B3 classic bus bundle, 3-bit address / 8-bit data.
//
// Signals
//   adr[2:0]      register address        (master -> slave)
//   dat_m2s[7:0]  write data              (master -> slave)
//   dat_s2m[7:0]  read data               (slave  -> master)
//   we            write enable            (master -> slave)
//   stb, cyc      strobe / cycle valid    (master -> slave)
//   ack           access acknowledge      (slave  -> master)
// -----------------------------------------------------------------------------
interface wishbone_b3;
    logic [2:0] adr;
    logic [7:0] dat_m2s;
    logic [7:0] dat_s2m;
    logic       we;
    logic       stb;
    logic       cyc;
    logic       ack;

    modport master (output adr, dat_m2s, we, stb, cyc, input dat_s2m, ack);
    modport slave  (input adr, dat_m2s, we, stb, cyc, output dat_s2m, ack);
endinterface

// File: rtl/i2c_temp_poller.sv
// -----------------------------------------------------------------------------
// i2c_temp_poller : drives a Wishbone I2C master core to read a 16-bit
// temperature register from an I2C sensor at a fixed polling interval.
//
// After reset the core prescaler and enable are programmed, then every
// POLL_CYCLES clocks (while enable is high) a two-byte read is performed:
// address+START, read MSB with ACK, read LSB with NACK+STOP.
//
// Parameters
//   PRESCALE        I2C core prescale value (adr 0/1)
//   SLAVE_ADDR      7-bit sensor address
//   POLL_CYCLES     clocks from end of one read to start of the next
//   TIMEOUT_CYCLES  status-poll limit (only with I2C_POLL_TIMEOUT_EN)
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   bus             Wishbone master towards the I2C core
//   enable          allows new reads to start
//   temp            last reading {MSB, LSB}
//   temp_valid      one-cycle pulse when temp updates
//   nack_err        sticky: slave NACK (or status timeout); cleared by a good read
//   busy            high whenever the controller is not idle
//
// Configuration macro
//   I2C_POLL_TIMEOUT_EN  when defined, a status poll lasting TIMEOUT_CYCLES
//                        flags nack_err and restarts initialisation.
// -----------------------------------------------------------------------------
module i2c_temp_poller #(
    parameter logic [15:0] PRESCALE       = 16'd99,
    parameter logic [6:0]  SLAVE_ADDR     = 7'h48,
    parameter logic [31:0] POLL_CYCLES    = 32'd5_000_000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50_000
) (
    input  logic        clk,
    input  logic        rst,
    wishbone_b3.master  bus,
    input  logic        enable,
    output logic [15:0] temp,
    output logic        temp_valid,
    output logic        nack_err,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_INIT_PRL, S_INIT_PRH, S_INIT_CTR, S_IDLE,
        S_TXR, S_CR_STA, S_POLL, S_CHK,
        S_CR_RD1, S_RD_MSB, S_CR_RD2, S_RD_LSB,
        S_DONE, S_CR_STO, S_NACK
    } state_t;

    state_t      state_q, state_d;
    state_t      ret_q, ret_d;          // where POLL goes once TIP clears
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [2:0]  adr_q, adr_d;
    logic [7:0]  dat_q, dat_d;
    logic [31:0] cnt_q, cnt_d;          // interval counter
    logic        rxack_q, rxack_d;      // SR bit7 from the last status read
    logic [7:0]  msb_q, msb_d;
    logic [7:0]  lsb_q, lsb_d;
    logic [15:0] temp_q, temp_d;
    logic        temp_valid_q, temp_valid_d;
    logic        nack_err_q, nack_err_d;

    // Per-state bus access descriptor
    logic        acc_en;
    logic [2:0]  acc_adr;
    logic        acc_we;
    logic [7:0]  acc_dat;
    logic        acc_done;

`ifdef I2C_POLL_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        cnt_d        = cnt_q;
        rxack_d      = rxack_q;
        msb_d        = msb_q;
        lsb_d        = lsb_q;
        temp_d       = temp_q;
        temp_valid_d = 1'b0;
        nack_err_d   = nack_err_q;
        acc_en       = 1'b1;
        acc_adr      = 3'd0;
        acc_we       = 1'b0;
        acc_dat      = 8'h00;
        acc_done     = 1'b0;

        case (state_q)
            S_INIT_PRL: begin acc_adr = 3'd0; acc_we = 1'b1; acc_dat = PRESCALE[7:0];  end
            S_INIT_PRH: begin acc_adr = 3'd1; acc_we = 1'b1; acc_dat = PRESCALE[15:8]; end
            S_INIT_CTR: begin acc_adr = 3'd2; acc_we = 1'b1; acc_dat = 8'h80;          end
            S_TXR:      begin acc_adr = 3'd3; acc_we = 1'b1; acc_dat = {SLAVE_ADDR, 1'b1}; end
            S_CR_STA:   begin acc_adr = 3'd4; acc_we = 1'b1; acc_dat = 8'h90;          end
            S_POLL:     begin acc_adr = 3'd4; end
            S_CR_RD1:   begin acc_adr = 3'd4; acc_we = 1'b1; acc_dat = 8'h20;          end
            S_RD_MSB:   begin acc_adr = 3'd3; end
            S_CR_RD2:   begin acc_adr = 3'd4; acc_we = 1'b1; acc_dat = 8'h68;          end
            S_RD_LSB:   begin acc_adr = 3'd3; end
            S_CR_STO:   begin acc_adr = 3'd4; acc_we = 1'b1; acc_dat = 8'h40;          end
            default:    acc_en = 1'b0;
        endcase

        // Generic access engine: launch when the bus is idle, hold everything
        // until ack, then drop cyc/stb. The next state always starts with
        // cyc low, giving the mandatory idle cycle between accesses.
        if (acc_en) begin
            if (!cyc_q) begin
                cyc_d = 1'b1;
                stb_d = 1'b1;
                adr_d = acc_adr;
                we_d  = acc_we;
                dat_d = acc_dat;
            end else if (bus.ack) begin
                cyc_d    = 1'b0;
                stb_d    = 1'b0;
                acc_done = 1'b1;
            end
        end

        case (state_q)
            S_INIT_PRL: if (acc_done) state_d = S_INIT_PRH;
            S_INIT_PRH: if (acc_done) state_d = S_INIT_CTR;
            S_INIT_CTR: if (acc_done) begin
                state_d = S_IDLE;
                cnt_d   = 32'd0;
            end
            S_IDLE: begin
                if (cnt_q >= POLL_CYCLES - 32'd1) begin
                    // Launch the TXR write directly so the bus access starts
                    // exactly POLL_CYCLES after the previous read ended.
                    if (enable) begin
                        cnt_d   = 32'd0;
                        state_d = S_TXR;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        adr_d   = 3'd3;
                        we_d    = 1'b1;
                        dat_d   = {SLAVE_ADDR, 1'b1};
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_TXR:    if (acc_done) state_d = S_CR_STA;
            S_CR_STA: if (acc_done) begin state_d = S_POLL; ret_d = S_CHK;    end
            S_POLL: begin
                if (acc_done) begin
                    rxack_d = bus.dat_s2m[7];
                    if (!bus.dat_s2m[1]) state_d = ret_q;
                end
            end
            S_CHK:    state_d = rxack_q ? S_CR_STO : S_CR_RD1;
            S_CR_RD1: if (acc_done) begin state_d = S_POLL; ret_d = S_RD_MSB; end
            S_RD_MSB: if (acc_done) begin msb_d = bus.dat_s2m; state_d = S_CR_RD2; end
            S_CR_RD2: if (acc_done) begin state_d = S_POLL; ret_d = S_RD_LSB; end
            S_RD_LSB: if (acc_done) begin lsb_d = bus.dat_s2m; state_d = S_DONE; end
            S_DONE: begin
                temp_d       = {msb_q, lsb_q};
                temp_valid_d = 1'b1;
                nack_err_d   = 1'b0;
                state_d      = S_IDLE;
            end
            S_CR_STO: if (acc_done) begin state_d = S_POLL; ret_d = S_NACK; end
            S_NACK: begin
                nack_err_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_INIT_PRL;
        endcase

`ifdef I2C_POLL_TIMEOUT_EN
        tmo_d = tmo_q;
        if (state_q == S_POLL) tmo_d = tmo_q + 16'd1;
        if (state_d == S_POLL && state_q != S_POLL) tmo_d = 16'd0;
        // A core stuck in TIP: give up on the read and reprogram the core.
        if (state_q == S_POLL && tmo_q >= TIMEOUT_CYCLES) begin
            nack_err_d = 1'b1;
            state_d    = S_INIT_PRL;
            cyc_d      = 1'b0;
            stb_d      = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_INIT_PRL;
            ret_q        <= S_CHK;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= 3'd0;
            dat_q        <= 8'h00;
            cnt_q        <= 32'd0;
            rxack_q      <= 1'b0;
            msb_q        <= 8'h00;
            lsb_q        <= 8'h00;
            temp_q       <= 16'h0000;
            temp_valid_q <= 1'b0;
            nack_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            cnt_q        <= cnt_d;
            rxack_q      <= rxack_d;
            msb_q        <= msb_d;
            lsb_q        <= lsb_d;
            temp_q       <= temp_d;
            temp_valid_q <= temp_valid_d;
            nack_err_q   <= nack_err_d;
        end
    end

`ifdef I2C_POLL_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= 16'd0;
        else     tmo_q <= tmo_d;
    end
`endif

    assign bus.cyc     = cyc_q;
    assign bus.stb     = stb_q;
    assign bus.we      = we_q;
    assign bus.adr     = adr_q;
    assign bus.dat_m2s = dat_q;
    assign temp        = temp_q;
    assign temp_valid  = temp_valid_q;
    assign nack_err    = nack_err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_temp_poller.sv
// -----------------------------------------------------------------------------
// tb_i2c_temp_poller : directed testbench for i2c_temp_poller with a
// behavioural I2C-core/sensor model on the Wishbone bus.
// -----------------------------------------------------------------------------
module tb_i2c_temp_poller;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] temp;
    logic        temp_valid;
    logic        nack_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    wishbone_b3 bus();

    i2c_temp_poller #(
        .PRESCALE(16'd99), .SLAVE_ADDR(7'h48),
        .POLL_CYCLES(32'd100), .TIMEOUT_CYCLES(16'd200)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .enable(enable),
        .temp(temp), .temp_valid(temp_valid), .nack_err(nack_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- I2C core / sensor model ----------------
    int         ack_delay = 0;
    int         tip_reads = 0;
    bit         nack_mode = 0;
    bit         tip_stuck = 0;
    logic [7:0] msb_val = 8'h00;
    logic [7:0] lsb_val = 8'h00;
    int         wcnt = 0;
    int         tip_left = 0;
    logic [7:0] last_cmd = 8'h00;
    logic       rx;

    logic [2:0] log_adr[$];
    logic       log_we[$];
    logic [7:0] log_dat[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ack     <= 1'b0;
            bus.dat_s2m <= 8'h00;
            wcnt     = 0;
            last_cmd = 8'h00;
        end else if (!bus.cyc || !bus.stb) begin
            bus.ack <= 1'b0;
            wcnt = 0;
        end else if (bus.ack) begin
            bus.ack <= 1'b0;
            wcnt = 0;
            log_adr.push_back(bus.adr);
            log_we.push_back(bus.we);
            log_dat.push_back(bus.we ? bus.dat_m2s : bus.dat_s2m);
        end else if (wcnt >= ack_delay) begin
            bus.ack <= 1'b1;
            wcnt = 0;
            if (bus.we) begin
                if (bus.adr == 3'd4) begin
                    last_cmd = bus.dat_m2s;
                    tip_left = tip_reads;
                end
                bus.dat_s2m <= 8'h00;
            end else if (bus.adr == 3'd4) begin
                rx = nack_mode && (last_cmd == 8'h90);
                if (tip_stuck) bus.dat_s2m <= {rx, 7'b0000010};
                else if (tip_left > 0) begin
                    tip_left--;
                    bus.dat_s2m <= {rx, 7'b0000010};
                end else bus.dat_s2m <= {rx, 7'b0000000};
            end else if (bus.adr == 3'd3) begin
                bus.dat_s2m <= (last_cmd == 8'h20) ? msb_val : lsb_val;
            end else begin
                bus.dat_s2m <= 8'h00;
            end
        end else begin
            wcnt++;
        end
    end

    // ---------------- Bus / output monitor (negedge) ----------------
    int         cycle_n = 0;
    int         proto_viol = 0;
    int         txr_seen = 0, txr_cycle = 0;
    int         tv_count = 0, tv_long = 0, tv_cycle = 0;
    int         cr90_cycle = 0, nack_cycle = 0;
    logic       p_cyc = 0, p_ack = 0, p_we = 0, p_tv = 0, p_nack = 0;
    logic [2:0] p_adr = 0;
    logic [7:0] p_dat = 0;

    always @(negedge clk) begin
        cycle_n++;
        if (!rst) begin
            if (bus.stb !== bus.cyc) proto_viol++;
            if (p_cyc && !p_ack && bus.cyc &&
                (bus.adr !== p_adr || bus.we !== p_we || bus.dat_m2s !== p_dat)) proto_viol++;
            if (p_cyc && p_ack && bus.cyc) proto_viol++;
            if (bus.cyc && !p_cyc && bus.we && bus.adr == 3'd3) begin
                txr_seen++;
                txr_cycle = cycle_n;
            end
            if (bus.cyc && bus.ack && bus.we && bus.adr == 3'd4 && bus.dat_m2s == 8'h90)
                cr90_cycle = cycle_n;
            if (temp_valid) begin
                tv_count++;
                tv_cycle = cycle_n;
                if (p_tv) tv_long++;
            end
            if (nack_err && !p_nack) nack_cycle = cycle_n;
        end
        p_cyc  = bus.cyc;
        p_ack  = bus.ack;
        p_we   = bus.we;
        p_adr  = bus.adr;
        p_dat  = bus.dat_m2s;
        p_tv   = temp_valid;
        p_nack = nack_err;
    end

    // ---------------- Bounded waits (report ok, tests compare) ----------------
    task automatic wait_idle(input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk); #1;
            if (!busy) begin ok = 1; break; end
        end
    endtask

    task automatic wait_tv(input int target, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk); #1;
            if (tv_count >= target) begin ok = 1; break; end
        end
    endtask

    task automatic wait_txr(input int target, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk); #1;
            if (txr_seen >= target) begin ok = 1; break; end
        end
    endtask

    task automatic wait_log(input int n, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk); #1;
            if (log_adr.size() >= n) begin ok = 1; break; end
        end
    endtask

    task automatic wait_cmd(input logic [7:0] cmd, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk); #1;
            foreach (log_adr[k])
                if (log_we[k] && log_adr[k] == 3'd4 && log_dat[k] == cmd) ok = 1;
        end
    endtask

    task automatic clear_log();
        log_adr.delete();
        log_we.delete();
        log_dat.delete();
    endtask

    logic [2:0] wr_adr[$];
    logic [7:0] wr_dat[$];
    logic [7:0] rd3_dat[$];
    int         sr_reads;

    task automatic collect();
        wr_adr.delete(); wr_dat.delete(); rd3_dat.delete();
        sr_reads = 0;
        foreach (log_adr[k]) begin
            if (log_we[k]) begin
                wr_adr.push_back(log_adr[k]);
                wr_dat.push_back(log_dat[k]);
            end else if (log_adr[k] == 3'd3) rd3_dat.push_back(log_dat[k]);
            else if (log_adr[k] == 3'd4) sr_reads++;
        end
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        rst = 1'b1; enable = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.cyc !== 1'b0)      begin errors++; $display("FAIL reset_cyc: got %b expected 0", bus.cyc); end
        checks++; if (bus.stb !== 1'b0)      begin errors++; $display("FAIL reset_stb: got %b expected 0", bus.stb); end
        checks++; if (bus.we !== 1'b0)       begin errors++; $display("FAIL reset_we: got %b expected 0", bus.we); end
        checks++; if (bus.adr !== 3'd0)      begin errors++; $display("FAIL reset_adr: got %0h expected 0", bus.adr); end
        checks++; if (bus.dat_m2s !== 8'h00) begin errors++; $display("FAIL reset_dat: got %0h expected 0", bus.dat_m2s); end
        checks++; if (temp !== 16'h0000)     begin errors++; $display("FAIL reset_temp: got %0h expected 0", temp); end
        checks++; if (temp_valid !== 1'b0)   begin errors++; $display("FAIL reset_tv: got %b expected 0", temp_valid); end
        checks++; if (nack_err !== 1'b0)     begin errors++; $display("FAIL reset_nack: got %b expected 0", nack_err); end
        checks++; if (busy !== 1'b1)         begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
        $display("test_reset: outputs checked while rst=1");
    endtask

    task automatic test_init();
        bit ok;
        logic [2:0] ea [3] = '{3'd0, 3'd1, 3'd2};
        logic [7:0] ed [3] = '{8'h63, 8'h00, 8'h80};
        clear_log();
        rst = 1'b0;
        wait_log(3, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL init_wait: got %0d accesses expected 3", log_adr.size()); end
        for (int i = 0; i < 3 && i < log_adr.size(); i++) begin
            checks++;
            if (log_adr[i] !== ea[i] || log_we[i] !== 1'b1 || log_dat[i] !== ed[i]) begin
                errors++;
                $display("FAIL init_wr%0d: got adr=%0d we=%b dat=%02h expected adr=%0d we=1 dat=%02h",
                         i, log_adr[i], log_we[i], log_dat[i], ea[i], ed[i]);
            end
        end
        wait_idle(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL init_idle: busy=%b expected 0", busy); end
        // enable low: counter saturates, nothing else happens
        repeat (300) @(negedge clk);
        #1;
        checks++; if (log_adr.size() != 3) begin errors++; $display("FAIL init_hold: got %0d accesses expected 3", log_adr.size()); end
        checks++; if (proto_viol !== 0) begin errors++; $display("FAIL init_proto: got %0d violations expected 0", proto_viol); end
        $display("test_init: %0d accesses logged, busy=%b", log_adr.size(), busy);
    endtask

    task automatic test_read();
        bit ok;
        int tv0, en_cycle, t_tv, txr0;
        logic [2:0] ea [4] = '{3'd3, 3'd4, 3'd4, 3'd4};
        logic [7:0] ed [4] = '{8'h91, 8'h90, 8'h20, 8'h68};
        ack_delay = 0; tip_reads = 1; nack_mode = 0; msb_val = 8'h19; lsb_val = 8'h80;
        clear_log();
        tv0 = tv_count;
        en_cycle = cycle_n;
        enable = 1'b1;
        wait_tv(tv0 + 1, 600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL read_wait: got no temp_valid expected 1 pulse"); end
        checks++; if (txr_cycle - en_cycle != 1) begin errors++; $display("FAIL read_start: got %0d cycles expected 1", txr_cycle - en_cycle); end
        checks++; if (temp !== 16'h1980) begin errors++; $display("FAIL read_temp: got %04h expected 1980", temp); end
        checks++; if (nack_err !== 1'b0) begin errors++; $display("FAIL read_nack: got %b expected 0", nack_err); end
        t_tv = tv_cycle;
        txr0 = txr_seen;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (tv_count != tv0 + 1 || tv_long != 0) begin errors++; $display("FAIL read_tv_width: got pulses=%0d long=%0d expected 1/0", tv_count - tv0, tv_long); end
        collect();
        checks++; if (wr_adr.size() != 4) begin errors++; $display("FAIL read_nwr: got %0d writes expected 4", wr_adr.size()); end
        for (int i = 0; i < 4 && i < wr_adr.size(); i++) begin
            checks++;
            if (wr_adr[i] !== ea[i] || wr_dat[i] !== ed[i]) begin
                errors++;
                $display("FAIL read_wr%0d: got adr=%0d dat=%02h expected adr=%0d dat=%02h", i, wr_adr[i], wr_dat[i], ea[i], ed[i]);
            end
        end
        checks++; if (rd3_dat.size() != 2 || rd3_dat[0] !== 8'h19 || rd3_dat[1] !== 8'h80) begin errors++; $display("FAIL read_rxdata: got %0d reads expected 19,80", rd3_dat.size()); end
        wait_txr(txr0 + 1, 200, ok);
        checks++; if (!ok || txr_cycle - t_tv != 100) begin errors++; $display("FAIL read_interval: got %0d cycles expected 100", txr_cycle - t_tv); end
        $display("test_read: temp=%04h interval=%0d", temp, txr_cycle - t_tv);
    endtask

    task automatic test_nack();
        bit ok;
        int tv0, txr0;
        logic [7:0] ed [3] = '{8'h91, 8'h90, 8'h40};
        wait_idle(600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL nack_pre_idle: busy=%b expected 0", busy); end
        nack_mode = 1; msb_val = 8'h55; lsb_val = 8'hAA;
        clear_log();
        tv0 = tv_count; txr0 = txr_seen;
        wait_txr(txr0 + 1, 200, ok);
        if (ok) wait_idle(600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL nack_wait: busy=%b expected 0", busy); end
        checks++; if (nack_err !== 1'b1) begin errors++; $display("FAIL nack_flag: got %b expected 1", nack_err); end
        checks++; if (temp !== 16'h1980) begin errors++; $display("FAIL nack_temp: got %04h expected 1980", temp); end
        checks++; if (tv_count != tv0) begin errors++; $display("FAIL nack_tv: got %0d pulses expected 0", tv_count - tv0); end
        collect();
        checks++; if (wr_adr.size() != 3 || rd3_dat.size() != 0) begin errors++; $display("FAIL nack_nwr: got %0d writes %0d reads expected 3/0", wr_adr.size(), rd3_dat.size()); end
        for (int i = 0; i < 3 && i < wr_dat.size(); i++) begin
            checks++;
            if (wr_dat[i] !== ed[i]) begin errors++; $display("FAIL nack_wr%0d: got %02h expected %02h", i, wr_dat[i], ed[i]); end
        end
        $display("test_nack: nack_err=%b temp=%04h", nack_err, temp);
    endtask

    task automatic test_recover();
        bit ok;
        int tv0;
        nack_mode = 0; msb_val = 8'h12; lsb_val = 8'h34;
        tv0 = tv_count;
        wait_tv(tv0 + 1, 600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL recover_wait: got no temp_valid expected 1"); end
        checks++; if (temp !== 16'h1234) begin errors++; $display("FAIL recover_temp: got %04h expected 1234", temp); end
        checks++; if (nack_err !== 1'b0) begin errors++; $display("FAIL recover_nack: got %b expected 0", nack_err); end
        $display("test_recover: temp=%04h nack_err=%b", temp, nack_err);
    endtask

    task automatic test_slow();
        bit ok;
        int tv0, pv0;
        ack_delay = 3; tip_reads = 10; msb_val = 8'h0A; lsb_val = 8'h5C;
        clear_log();
        tv0 = tv_count; pv0 = proto_viol;
        wait_tv(tv0 + 1, 3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL slow_wait: got no temp_valid expected 1"); end
        checks++; if (temp !== 16'h0A5C) begin errors++; $display("FAIL slow_temp: got %04h expected 0a5c", temp); end
        checks++; if (proto_viol != pv0) begin errors++; $display("FAIL slow_proto: got %0d violations expected 0", proto_viol - pv0); end
        collect();
        checks++; if (sr_reads != 33) begin errors++; $display("FAIL slow_sr_reads: got %0d expected 33", sr_reads); end
        checks++; if (wr_adr.size() != 4) begin errors++; $display("FAIL slow_nwr: got %0d writes expected 4", wr_adr.size()); end
        $display("test_slow: temp=%04h sr_reads=%0d", temp, sr_reads);
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_idle(600, ok);
        clear_log();
        wait_cmd(8'h20, 3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_wait: got no CR=20 expected one"); end
        repeat (5) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++; if (bus.cyc !== 1'b0 || bus.stb !== 1'b0) begin errors++; $display("FAIL rstmid_cyc: got cyc=%b stb=%b expected 0/0", bus.cyc, bus.stb); end
        checks++; if (bus.adr !== 3'd0 || bus.dat_m2s !== 8'h00 || bus.we !== 1'b0) begin errors++; $display("FAIL rstmid_bus: got adr=%0d dat=%02h we=%b expected 0", bus.adr, bus.dat_m2s, bus.we); end
        checks++; if (temp !== 16'h0000 || temp_valid !== 1'b0 || nack_err !== 1'b0) begin errors++; $display("FAIL rstmid_out: got temp=%04h tv=%b nack=%b expected 0", temp, temp_valid, nack_err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got %b expected 1", busy); end
        ack_delay = 0; tip_reads = 0;
        repeat (3) @(negedge clk);
        #1;
        clear_log();
        rst = 1'b0;
        wait_log(3, 200, ok);
        checks++; if (!ok || log_adr[0] !== 3'd0 || log_dat[0] !== 8'h63 || log_adr[2] !== 3'd2 || log_dat[2] !== 8'h80) begin
            errors++; $display("FAIL rstmid_reinit: got %0d accesses, first adr/dat expected 0/63 then 2/80", log_adr.size());
        end
        $display("test_reset_mid: reinit with %0d accesses", log_adr.size());
    endtask

`ifdef I2C_POLL_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        wait_idle(600, ok);
        tip_stuck = 1;
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (nack_err) begin ok = 1; break; end
        end
        clear_log();
        checks++; if (!ok) begin errors++; $display("FAIL tmo_nack: got %b expected 1", nack_err); end
        checks++; if (nack_cycle - cr90_cycle < 200 || nack_cycle - cr90_cycle > 205) begin errors++; $display("FAIL tmo_time: got %0d cycles expected 200..205", nack_cycle - cr90_cycle); end
        tip_stuck = 0;
        wait_log(1, 100, ok);
        checks++; if (!ok || log_adr[0] !== 3'd0 || log_we[0] !== 1'b1 || log_dat[0] !== 8'h63) begin errors++; $display("FAIL tmo_reinit: got %0d accesses expected write 0/63 first", log_adr.size()); end
        $display("test_timeout: nack after %0d cycles", nack_cycle - cr90_cycle);
    endtask
`endif

    initial begin
        #500_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        test_reset();
        test_init();
        test_read();
        test_nack();
        test_recover();
        test_slow();
        test_reset_mid();
`ifdef I2C_POLL_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_temp_poller.md
I2C_TEMP_POLLER -- requirements
Module: i2c_temp_poller

Interface
REQ-001 SHALL have parameter PRESCALE, default 16'd99; value written to the I2C core prescale registers.
REQ-002 SHALL have parameter SLAVE_ADDR, default 7'h48; 7-bit address of the temperature sensor.
REQ-003 SHALL have parameter POLL_CYCLES, default 32'd5_000_000; clk cycles from the end of one read to the start of the next.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16'd50_000; status-poll limit, used only with the macro in REQ-026.
REQ-005 SHALL have port clk, input, 1 bit; the single clock.
REQ-006 SHALL have port rst, input, 1 bit; asynchronous, active-high reset.
REQ-007 SHALL have port bus, wishbone_b3.master, with adr[2:0], dat_m2s[7:0], dat_s2m[7:0], we, stb, cyc and ack; it drives wb_i2c_master.
REQ-008 SHALL have port enable, input, 1 bit; when high, polling cycles are permitted.
REQ-009 SHALL have port temp, output, 16 bits; last sensor reading, {MSB, LSB}.
REQ-010 SHALL have port temp_valid, output, 1 bit; one-cycle pulse when temp updates.
REQ-011 SHALL have port nack_err, output, 1 bit; sticky flag for a slave NACK or a timeout.
REQ-012 SHALL have port busy, output, 1 bit; high in every state except IDLE.

Function
REQ-013 SHALL run each bus access as follows: assert cyc and stb together with adr, we and dat_m2s; hold all of them stable until ack; drop cyc and stb in the cycle after ack; keep them low for at least one cycle before the next access.
REQ-014 SHALL latch read data from dat_s2m in the ack cycle.
REQ-015 SHALL run the initialisation sequence INIT_PRL -> INIT_PRH -> INIT_CTR after reset:
- write adr 0 = PRESCALE[7:0];
- write adr 1 = PRESCALE[15:8];
- write adr 2 = 8'h80 (core enable);
- then enter IDLE with the interval counter at 0.
REQ-016 SHALL count in IDLE; when the counter reaches POLL_CYCLES-1 and enable=1, it SHALL clear the counter and start a read. If enable=0, the counter SHALL hold at POLL_CYCLES-1.
REQ-017 SHALL perform each read in this order:
- ADDR: TXR write, adr 3 = {SLAVE_ADDR,1'b1};
- CR write, adr 4 = 8'h90 (STA|WR);
- POLL;
- CHK: if SR bit7 (RxACK) = 1, go to NACK;
- CR write 8'h20 (RD, ACK);
- POLL;
- read adr 3 -> msb;
- CR write 8'h68 (RD|NACK|STO);
- POLL;
- read adr 3 -> lsb;
- DONE.
REQ-018 SHALL, in POLL, repeatedly read adr 4 (SR) until bit1 (TIP) = 0; the SR value read last SHALL be kept for CHK.
REQ-019 SHALL, in DONE, load temp = {msb, lsb}, pulse temp_valid for exactly one cycle, clear nack_err and return to IDLE, all in the same cycle.
REQ-020 SHALL, in NACK, write CR 8'h40 (STO), POLL, set nack_err, leave temp unchanged, not pulse temp_valid, and return to IDLE.
REQ-021 SHALL ignore a change on enable during an in-progress read; the read completes.
REQ-022 SHALL never issue a write to adr 0-2 after initialisation.

Reset
REQ-023 SHALL, while rst=1 (asynchronously), set cyc=0, stb=0, we=0, adr=0, dat_m2s=0, temp=0, temp_valid=0, nack_err=0, the interval counter to 0 and the state to INIT_PRL.
REQ-024 SHALL keep busy=1 during reset.
REQ-025 SHALL, when rst asserts mid-read, abandon the read with no STOP issued (rst also resets the I2C core) and rerun initialisation after release.

Configuration
REQ-026 SHALL implement macro I2C_POLL_TIMEOUT_EN as follows.
- Defined: a 16-bit counter clears on entry to each POLL and increments each cycle in POLL. On reaching TIMEOUT_CYCLES, the block SHALL set nack_err and re-enter the initialisation sequence, abandoning the read with no temp_valid pulse.
- Undefined: the counter is absent, POLL waits indefinitely, and TIMEOUT_CYCLES is unused.

Verification
REQ-027 SHALL pass: after reset, bus writes (0,0x63), (1,0x00), (2,0x80) appear in order, each access waits for ack, and cyc drops between accesses.
REQ-028 SHALL pass: with a sensor model at 0x48 returning 0x19,0x80 and POLL_CYCLES=100, temp=16'h1980, temp_valid is high for exactly 1 cycle, and the next TXR write follows 100 cycles later.
REQ-029 SHALL pass: with the slave NACKing the address, CR=0x40 is written, nack_err=1, temp is unchanged, and the next good read clears nack_err.
REQ-030 SHALL pass: with ack delayed 3 cycles on every access and TIP held high for 10 SR reads, all transactions stay stable until ack and the result is correct.
REQ-031 SHALL pass: with rst asserted during the second POLL, all outputs clear immediately and re-initialisation starts after release.
REQ-032 SHALL pass, with I2C_POLL_TIMEOUT_EN defined and TIMEOUT_CYCLES=200: with TIP stuck at 1, nack_err=1 after 200 cycles and a write (0,0x63) follows.
